// File: rtl/accel_load_sequencer_if.sv
// Write/read bus between the load sequencer (master) and the accelerator's
// local memories (slave).
interface accel_load_sequencer_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic        wvalid;
    logic [31:0] araddr;
    logic        arvalid;
    logic [31:0] rdata;

    modport master (output awaddr, awvalid, wdata, wvalid, araddr, arvalid, input rdata);
    modport slave  (input awaddr, awvalid, wdata, wvalid, araddr, arvalid, output rdata);
endinterface

// File: rtl/accel_load_sequencer.sv
// Streams weight/bias/pixel words from a source buffer into accelerator memory,
// waits for the completion interrupt, then reads the result region back.
module accel_load_sequencer #(
    parameter int          DATA_W      = 16,
    parameter int          CNT_W       = 16,
    parameter int          GAP_W       = 4,
    parameter int          RES_LEN     = 900,
    parameter int          TIMEOUT     = 50000,
    parameter logic [31:0] WEIGHT_ADDR = 32'hd333_0000,
    parameter logic [31:0] BIAS_ADDR   = 32'hd444_0000,
    parameter logic [31:0] PIXEL_ADDR  = 32'hd555_0000,
    parameter logic [31:0] RESULT_ADDR = 32'hd000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       weight_len,
    input  logic [CNT_W-1:0]       bias_len,
    input  logic [CNT_W-1:0]       pixel_len,
    input  logic [GAP_W-1:0]       gap,
    output logic [CNT_W-1:0]       src_addr,
    output logic                   src_ren,
    input  logic [DATA_W-1:0]      src_rdata,
    accel_load_sequencer_if.master bus,
    input  logic                   interrupt_signal,
    output logic [31:0]            res_data,
    output logic                   res_valid,
    output logic [CNT_W-1:0]       res_index,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    typedef enum logic [3:0] {IDLE, FETCH, WRITE, WGAP, WAIT_IRQ, READ, RCAP, RGAP, DONE} state_t;

    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RES_N    = CNT_W'(RES_LEN);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_LEN > 0 ? RES_LEN - 1 : 0);
    localparam logic [1:0]       SEC_W = 2'd0, SEC_B = 2'd1, SEC_P = 2'd2, SEC_NONE = 2'd3;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_w, len_b, len_p, idx, ridx, cur_len;
    logic [GAP_W-1:0] gap_r, gap_cnt;
    logic [1:0]       sec, nxt_sec, start_sec;
    logic [TW-1:0]    timer;
    logic             accept, sec_end, gap_end;

    // First non-empty section at or after 'from'; SEC_NONE when loading is finished.
    function automatic logic [1:0] first_sec(input logic [1:0] from, input logic [CNT_W-1:0] lw,
                                             input logic [CNT_W-1:0] lb, input logic [CNT_W-1:0] lp);
        if (from == SEC_W && lw != '0) return SEC_W;
        if (from <= SEC_B && lb != '0) return SEC_B;
        if (from <= SEC_P && lp != '0) return SEC_P;
        return SEC_NONE;
    endfunction

    assign accept    = (state == IDLE) && start && !busy;
    assign start_sec = first_sec(SEC_W, weight_len, bias_len, pixel_len);
    assign cur_len   = (sec == SEC_W) ? len_w : (sec == SEC_B) ? len_b : len_p;
    assign sec_end   = (idx + CNT_W'(1)) == cur_len;
    assign nxt_sec   = first_sec(sec + 2'd1, len_w, len_b, len_p);
    assign gap_end   = gap_cnt == (gap_r - GAP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = (start_sec == SEC_NONE) ? WAIT_IRQ : FETCH;
            FETCH:    state_nxt = WRITE;
            WRITE: begin
                if (gap_r != '0)                      state_nxt = WGAP;
                else if (sec_end && nxt_sec == SEC_NONE) state_nxt = WAIT_IRQ;
                else                                  state_nxt = FETCH;
            end
            // sec was advanced to SEC_NONE by the final write
            WGAP:     if (gap_end) state_nxt = (sec == SEC_NONE) ? WAIT_IRQ : FETCH;
            WAIT_IRQ: begin
                if (interrupt_signal)     state_nxt = (RES_LEN == 0) ? DONE : READ;
                else if (timer == TO_LAST) state_nxt = DONE;
            end
            READ:     state_nxt = RCAP;
            RCAP: begin
                if (gap_r != '0)         state_nxt = RGAP;
                else if (ridx == RES_LAST) state_nxt = DONE;
                else                     state_nxt = READ;
            end
            RGAP:     if (gap_end) state_nxt = (ridx == RES_N) ? DONE : READ;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_w    <= '0;
            len_b    <= '0;
            len_p    <= '0;
            gap_r    <= '0;
            gap_cnt  <= '0;
            sec      <= SEC_W;
            idx      <= '0;
            ridx     <= '0;
            src_addr <= '0;
            timer    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (state != DONE && state_nxt == DONE) done <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    len_w    <= weight_len;
                    len_b    <= bias_len;
                    len_p    <= pixel_len;
                    gap_r    <= gap;
                    sec      <= start_sec;
                    idx      <= '0;
                    ridx     <= '0;
                    src_addr <= '0;
                    timer    <= '0;
                    done     <= 1'b0;
                    error    <= 1'b0;
                end
                WRITE: begin
                    src_addr <= src_addr + CNT_W'(1);
                    gap_cnt  <= '0;
                    if (sec_end) begin
                        idx <= '0;
                        sec <= nxt_sec;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                WGAP, RGAP: gap_cnt <= gap_cnt + GAP_W'(1);
                WAIT_IRQ: begin
                    timer <= timer + TW'(1);
                    if (!interrupt_signal && state_nxt == DONE) error <= 1'b1;
                end
                RCAP: begin
                    ridx    <= ridx + CNT_W'(1);
                    gap_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        src_ren     = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wvalid  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        res_data    = '0;
        res_valid   = 1'b0;
        res_index   = '0;
        busy        = (state != IDLE) && (state != DONE);
        case (state)
            FETCH: src_ren = 1'b1;
            WRITE: begin
                bus.awvalid = 1'b1;
                bus.wvalid  = 1'b1;
                bus.awaddr  = (sec == SEC_W) ? WEIGHT_ADDR : (sec == SEC_B) ? BIAS_ADDR : PIXEL_ADDR;
                bus.wdata   = {{(32 - DATA_W){1'b0}}, src_rdata};
            end
            READ: begin
                bus.arvalid = 1'b1;
                bus.araddr  = RESULT_ADDR + {{(30 - CNT_W){1'b0}}, ridx, 2'b00};
            end
            RCAP: begin
                res_valid = 1'b1;
                res_data  = bus.rdata;
                res_index = ridx;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_accel_load_sequencer.sv
// Self-checking bench: table-driven and randomized runs against a spec-level
// model of the write stream, result readback and timeout timing.
module tb_accel_load_sequencer;
    localparam int          CNT_W = 16, DATA_W = 16, GAP_W = 4, RES_LEN = 4, TIMEOUT = 100;
    localparam logic [31:0] WA = 32'hd333_0000, BA = 32'hd444_0000, PA = 32'hd555_0000;
    localparam logic [31:0] RA = 32'hd000_0000;

    typedef struct { int wl, bl, pl, g, irq_dly; bit mid_start, mid_irq; int exp_writes; bit exp_err; } vec_t;
    typedef struct { int cyc; logic [31:0] a; logic [31:0] d; logic [15:0] sa; } ev_t;
    typedef struct { logic [31:0] addr; int idx; } wexp_t;

    logic clk = 0, rst = 0, start = 0, irq = 0;
    logic [CNT_W-1:0]  weight_len = 0, bias_len = 0, pixel_len = 0;
    logic [GAP_W-1:0]  gap = 0;
    logic [CNT_W-1:0]  src_addr, res_index;
    logic              src_ren, res_valid, busy, done, error;
    logic [DATA_W-1:0] src_rdata;
    logic [31:0]       res_data;
    logic [15:0]       src_mem [0:255];

    int  n_cmp = 0, n_bad = 0, cyc = 0, done_cyc = -1, idle_viol = 0;
    bit  done_d = 0;
    ev_t wr_log[$], rd_log[$], rs_log[$];

    accel_load_sequencer_if bus();

    accel_load_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_W(GAP_W),
                           .RES_LEN(RES_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .weight_len(weight_len), .bias_len(bias_len), .pixel_len(pixel_len), .gap(gap),
        .src_addr(src_addr), .src_ren(src_ren), .src_rdata(src_rdata),
        .bus(bus.master), .interrupt_signal(irq),
        .res_data(res_data), .res_valid(res_valid), .res_index(res_index),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hbeef, a[31:16]};
    endfunction

    always @(posedge clk) if (src_ren) src_rdata <= src_mem[src_addr[7:0]];
    always @(posedge clk) bus.rdata <= bus.arvalid ? rd_fn(bus.araddr) : 32'h0;

    // Event monitor, sampled 1 time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (bus.awvalid === 1'b1) wr_log.push_back('{cyc, bus.awaddr, bus.wdata, src_addr});
        if (bus.arvalid === 1'b1) rd_log.push_back('{cyc, bus.araddr, 32'h0, 16'h0});
        if (res_valid === 1'b1)   rs_log.push_back('{cyc, 32'h0, res_data, res_index});
        if (done === 1'b1 && !done_d) done_cyc = cyc;
        done_d = (done === 1'b1);
        if (bus.wvalid !== bus.awvalid ||
            (bus.awvalid !== 1'b1 && (bus.awaddr !== 32'h0 || bus.wdata !== 32'h0)) ||
            (bus.arvalid !== 1'b1 && bus.araddr !== 32'h0))
            idle_viol = idle_viol + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        wexp_t model[$];
        int s, n, lw, ref_cyc, wait_enter, r0, budget;
        bit ms_done = 0, mi_done = 0;
        // Contiguous source layout: weights, then biases, then pixels.
        for (int i = 0; i < v.wl; i++) model.push_back('{WA, i});
        for (int i = 0; i < v.bl; i++) model.push_back('{BA, v.wl + i});
        for (int i = 0; i < v.pl; i++) model.push_back('{PA, v.wl + v.bl + i});
        n = model.size();
        wr_log.delete(); rd_log.delete(); rs_log.delete();
        idle_viol = 0; done_cyc = -1;

        @(negedge clk);
        weight_len = CNT_W'(v.wl); bias_len = CNT_W'(v.bl); pixel_len = CNT_W'(v.pl);
        gap = GAP_W'(v.g); start = 1; s = cyc + 1;
        @(negedge clk);
        start = 0;
        chk("start_flags{busy,done,error}", {busy, done, error}, 3'b100);

        lw         = s + 1 + (n - 1) * (2 + v.g);
        ref_cyc    = (n == 0) ? s : lw;
        wait_enter = (n == 0) ? s : lw + v.g + 1;
        budget = 0;
        while (done !== 1'b1 && budget < 3000) begin
            irq = 0; start = 0;
            if (v.mid_start && !ms_done && wr_log.size() == 2) begin
                start = 1; weight_len = 1; bias_len = 1; ms_done = 1;
            end
            if (v.mid_irq && !mi_done && wr_log.size() == 1) begin irq = 1; mi_done = 1; end
            if (v.irq_dly >= 0 && cyc == ref_cyc + v.irq_dly) irq = 1;
            @(negedge clk);
            budget++;
        end
        irq = 0; start = 0;
        chk("done_reached", done, 1'b1);

        chk("n_writes", wr_log.size(), v.exp_writes);
        for (int k = 0; k < wr_log.size() && k < n; k++) begin
            chk($sformatf("awaddr[%0d]", k), wr_log[k].a, model[k].addr);
            chk($sformatf("wdata[%0d]", k), wr_log[k].d, {16'h0, src_mem[model[k].idx]});
            chk($sformatf("src_addr[%0d]", k), wr_log[k].sa, model[k].idx);
            chk($sformatf("wr_cycle[%0d]", k), wr_log[k].cyc, s + 1 + k * (2 + v.g));
        end
        chk("error_flag", error, v.exp_err);
        if (v.irq_dly < 0) begin
            chk("n_reads_timeout", rd_log.size(), 0);
            chk("timeout_done_cycle", done_cyc, wait_enter + TIMEOUT);
        end else begin
            r0 = ref_cyc + v.irq_dly + 1;
            chk("n_reads", rd_log.size(), RES_LEN);
            chk("n_results", rs_log.size(), RES_LEN);
            for (int k = 0; k < rd_log.size() && k < RES_LEN; k++) begin
                chk($sformatf("araddr[%0d]", k), rd_log[k].a, RA + 32'(4 * k));
                chk($sformatf("rd_cycle[%0d]", k), rd_log[k].cyc, r0 + k * (2 + v.g));
            end
            for (int k = 0; k < rs_log.size() && k < RES_LEN; k++) begin
                chk($sformatf("res_cycle[%0d]", k), rs_log[k].cyc, r0 + k * (2 + v.g) + 1);
                chk($sformatf("res_data[%0d]", k), rs_log[k].d, rd_fn(RA + 32'(4 * k)));
                chk($sformatf("res_index[%0d]", k), rs_log[k].sa, k);
            end
            chk("read_done_cycle", done_cyc, r0 + (RES_LEN - 1) * (2 + v.g) + 1 + v.g + 1);
        end
        chk("idle_bus_violations", idle_viol, 0);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
        //           wl bl pl g  irq ms mi  nw err
        tbl[0] = '{4, 2, 3, 3, 10, 0, 0, 9, 0};
        tbl[1] = '{3, 1, 2, 0, 10, 0, 0, 6, 0};
        tbl[2] = '{2, 0, 2, 1,  5, 0, 0, 4, 0};
        tbl[3] = '{1, 1, 1, 2, -1, 0, 0, 3, 1};
        tbl[4] = '{0, 0, 0, 0,  3, 0, 0, 0, 0};
        tbl[5] = '{5, 0, 0, 2,  4, 1, 1, 5, 0};
        tbl[6] = '{0, 0, 3, 0, -1, 0, 0, 3, 1};

        #1 rst = 1;
        #20;
        chk("reset_outputs_nonzero", {src_addr, src_ren, bus.awaddr, bus.awvalid, bus.wdata,
            bus.wvalid, bus.araddr, bus.arvalid, res_data, res_valid, res_index,
            busy, done, error} != 0, 1'b0);
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) run(tbl[i]);

        // Asynchronous reset in the middle of a write cycle.
        @(negedge clk);
        weight_len = 3; bias_len = 0; pixel_len = 0; gap = 2; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 20 && bus.awvalid !== 1'b1; i++) @(negedge clk);
        chk("awvalid_before_reset", bus.awvalid, 1'b1);
        rst = 1;
        #1;
        chk("async_reset_outputs_nonzero", {src_addr, src_ren, bus.awaddr, bus.awvalid, bus.wdata,
            bus.wvalid, bus.araddr, bus.arvalid, res_data, res_valid, res_index,
            busy, done, error} != 0, 1'b0);
        @(negedge clk);
        rst = 0;
        run(tbl[2]);

        for (int r = 0; r < 10; r++) begin
            rv.wl = $urandom_range(0, 5); rv.bl = $urandom_range(0, 5); rv.pl = $urandom_range(0, 5);
            rv.g  = $urandom_range(0, 4);
            rv.irq_dly = ($urandom_range(0, 3) == 0) ? -1 : rv.g + 1 + $urandom_range(0, 15);
            rv.mid_start = 0; rv.mid_irq = 0;
            rv.exp_writes = rv.wl + rv.bl + rv.pl;
            rv.exp_err = (rv.irq_dly < 0);
            run(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule
